uart_rx_unit: RTL and testbench

//  UART receiver; the receive-side counterpart of the TxUnit transmitter, using the same frame configuration inputs.

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/uart_rx_unit_if.sv | 23 ++
 rtl/rx_tick_gen.sv | 50 +++++
 rtl/uart_rx_unit.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and config payload for the UART receive path.
package uart_pkg;

  localparam int unsigned OVS      = 16;
  localparam int unsigned MID_TICK = 7;
  localparam int unsigned TICK_W   = 4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  // Frame settings captured at start detection.
  typedef struct packed {
    logic       stop2;
    logic       len8;
    logic [1:0] parity;
    logic [1:0] baud;
  } rx_cfg_t;

  // Baud rate in Hz for a baud select code.
  function automatic int unsigned baud_hz(input logic [1:0] sel);
    int unsigned hz;
    hz = 9600;
    case (sel)
      BAUD_2400:  hz = 2400;
      BAUD_4800:  hz = 4800;
      BAUD_9600:  hz = 9600;
      BAUD_19200: hz = 19200;
    endcase
    return hz;
  endfunction

  // A parity bit is present only for the odd and even codes.
  function automatic logic parity_on(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// Serial line, frame configuration and receive results of the UART receiver.
interface uart_rx_unit_if;
  logic       data_tx;
  logic       stop_bits;
  logic       data_length;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       stop_error;

  modport master (
    output data_tx, stop_bits, data_length, parity_type, baud_rate,
    input  data_out, rx_active, rx_done, parity_error, stop_error
  );

  modport slave (
    input  data_tx, stop_bits, data_length, parity_type, baud_rate,
    output data_out, rx_active, rx_done, parity_error, stop_error
  );
endinterface

// File: rtl/rx_tick_gen.sv
// 16x oversampling tick generator; phase is realigned by clear on start detection.
module rx_tick_gen #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] baud_rate,
  input  logic       clear,
  output logic       tick
);
  import uart_pkg::*;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DIV_2400  = CLK_FREQ / (OVS * baud_hz(BAUD_2400));
  localparam int unsigned DIV_4800  = CLK_FREQ / (OVS * baud_hz(BAUD_4800));
  localparam int unsigned DIV_9600  = CLK_FREQ / (OVS * baud_hz(BAUD_9600));
  localparam int unsigned DIV_19200 = CLK_FREQ / (OVS * baud_hz(BAUD_19200));

  logic [CNT_W-1:0] div_last_c;
  logic [CNT_W-1:0] cnt_q;

  // Terminal count for the selected baud rate.
  always_comb begin
    div_last_c = CNT_W'(DIV_9600 - 1);
    case (baud_rate)
      BAUD_2400:  div_last_c = CNT_W'(DIV_2400 - 1);
      BAUD_4800:  div_last_c = CNT_W'(DIV_4800 - 1);
      BAUD_9600:  div_last_c = CNT_W'(DIV_9600 - 1);
      BAUD_19200: div_last_c = CNT_W'(DIV_19200 - 1);
    endcase
  end

  // Divider counter; tick is a registered one-cycle pulse per wrap.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == div_last_c) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver: start detect, mid-bit sampling of data/parity/stop, registered results.
module uart_rx_unit #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic           clock,
  input  logic           rst,
  uart_rx_unit_if.slave  bus
);
  import uart_pkg::*;

  logic [1:0]        sync_q;
  logic              rxs;
  logic              rxs_d;
  logic              tick;
  logic              start_c;
  logic              mid_c;
  logic              bit_end_c;
  logic [2:0]        last_bit_c;

  rx_state_e         state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic              stop_cnt, stop_cnt_n;
  logic [7:0]        shift_q, shift_n;
  logic              par_err_q, par_err_n;
  logic              stop_err_q, stop_err_n;
  rx_cfg_t           cfg_q, cfg_n;
  logic [7:0]        data_out_q, data_out_n;
  logic              par_out_q, par_out_n;
  logic              stop_out_q, stop_out_n;
  logic              rx_done_q, rx_done_n;
  logic              rx_active_q, rx_active_n;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], bus.data_tx};
      rxs_d  <= sync_q[1];
    end
  end

  assign rxs        = sync_q[1];
  assign start_c    = (state == ST_IDLE) && rxs_d && !rxs;
  assign mid_c      = tick && (tick_cnt == TICK_W'(MID_TICK));
  assign bit_end_c  = tick && (tick_cnt == TICK_W'(OVS - 1));
  assign last_bit_c = cfg_q.len8 ? 3'd7 : 3'd6;

  rx_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick_gen (
    .clock     (clock),
    .rst       (rst),
    .baud_rate (cfg_q.baud),
    .clear     (start_c),
    .tick      (tick)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      cfg_q       <= '0;
      data_out_q  <= '0;
      par_out_q   <= 1'b0;
      stop_out_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_cnt_n;
      bit_cnt     <= bit_cnt_n;
      stop_cnt    <= stop_cnt_n;
      shift_q     <= shift_n;
      par_err_q   <= par_err_n;
      stop_err_q  <= stop_err_n;
      cfg_q       <= cfg_n;
      data_out_q  <= data_out_n;
      par_out_q   <= par_out_n;
      stop_out_q  <= stop_out_n;
      rx_done_q   <= rx_done_n;
      rx_active_q <= rx_active_n;
    end
  end

  // Next-state and next-datapath logic for the frame FSM.
  always_comb begin
    state_n     = state;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    stop_cnt_n  = stop_cnt;
    shift_n     = shift_q;
    par_err_n   = par_err_q;
    stop_err_n  = stop_err_q;
    cfg_n       = cfg_q;
    data_out_n  = data_out_q;
    par_out_n   = par_out_q;
    stop_out_n  = stop_out_q;
    rx_done_n   = 1'b0;
    rx_active_n = rx_active_q;

    case (state)
      ST_IDLE: begin
        if (start_c) begin
          state_n     = ST_START;
          tick_cnt_n  = '0;
          bit_cnt_n   = '0;
          stop_cnt_n  = 1'b0;
          shift_n     = '0;
          par_err_n   = 1'b0;
          stop_err_n  = 1'b0;
          cfg_n       = '{stop2:  bus.stop_bits,
                          len8:   bus.data_length,
                          parity: bus.parity_type,
                          baud:   bus.baud_rate};
          rx_active_n = 1'b1;
        end
      end

      ST_START: begin
        if (mid_c) begin
          tick_cnt_n = '0;
          if (rxs) begin
            state_n     = ST_IDLE;
            rx_active_n = 1'b0;
          end else begin
            state_n = ST_DATA;
          end
        end else if (tick) begin
          tick_cnt_n = tick_cnt + TICK_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end_c) begin
          tick_cnt_n = '0;
          shift_n    = {rxs, shift_q[7:1]};
          bit_cnt_n  = bit_cnt + 3'd1;
          if (bit_cnt == last_bit_c) begin
            state_n = parity_on(cfg_q.parity) ? ST_PARITY : ST_STOP;
          end
        end else if (tick) begin
          tick_cnt_n = tick_cnt + TICK_W'(1);
        end
      end

      ST_PARITY: begin
        if (bit_end_c) begin
          tick_cnt_n = '0;
          par_err_n  = ((^shift_q) ^ rxs) != (cfg_q.parity == PAR_ODD);
          state_n    = ST_STOP;
        end else if (tick) begin
          tick_cnt_n = tick_cnt + TICK_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end_c) begin
          tick_cnt_n = '0;
          if (!rxs) begin
            stop_err_n = 1'b1;
          end
          if (cfg_q.stop2 && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else begin
            state_n = ST_DONE;
          end
        end else if (tick) begin
          tick_cnt_n = tick_cnt + TICK_W'(1);
        end
      end

      ST_DONE: begin
        data_out_n  = cfg_q.len8 ? shift_q : {1'b0, shift_q[7:1]};
        par_out_n   = par_err_q;
        stop_out_n  = stop_err_q;
        rx_done_n   = 1'b1;
        rx_active_n = 1'b0;
        state_n     = ST_IDLE;
      end

      default: begin
        state_n     = ST_IDLE;
        rx_active_n = 1'b0;
      end
    endcase
  end

  assign bus.data_out     = data_out_q;
  assign bus.parity_error = par_out_q;
  assign bus.stop_error   = stop_out_q;
  assign bus.rx_done      = rx_done_q;
  assign bus.rx_active    = rx_active_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit: directed frames plus randomized frames vs. a frame-level model.
module tb_uart_rx_unit;

  localparam int unsigned CLK_FREQ = 614_400;

  logic clock = 1'b0;
  logic rst;

  uart_rx_unit_if bus();

  uart_rx_unit #(.CLK_FREQ(CLK_FREQ)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic cap_act = 1'b0;

  // Expected held outputs, updated from the frame-level model.
  logic [7:0] exp_data = 8'h00;
  logic       exp_pe   = 1'b0;
  logic       exp_se   = 1'b0;

  // Count rx_done pulses and record rx_active at the pulse.
  always @(negedge clock) begin
    if (bus.rx_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      cap_act  = bus.rx_active;
    end
  end

  // Clocks per oversampling tick for a baud code.
  function automatic int tick_clks(input logic [1:0] b);
    return int'(CLK_FREQ) / (16 * (2400 << b));
  endfunction

  task automatic idle(input int clks);
    bus.data_tx = 1'b1;
    repeat (clks) @(negedge clock);
  endtask

  // Drive one frame on the line and update the expected results.
  task automatic send_frame(input logic [7:0] d, input logic s2, input logic l8,
                            input logic [1:0] par, input logic [1:0] br, input logic flip,
                            input logic [1:0] stop_low, input int last_ticks, input logic scramble);
    int tk;
    int nb;
    int ns;
    logic [7:0] dm;
    logic pbit;
    logic pon;
    tk   = tick_clks(br);
    nb   = l8 ? 8 : 7;
    ns   = s2 ? 2 : 1;
    dm   = l8 ? d : {1'b0, d[6:0]};
    pon  = (par == 2'b01) || (par == 2'b10);
    pbit = ((($countones(dm) % 2) == 0) == (par == 2'b01)) ^ flip;
    bus.stop_bits   = s2;
    bus.data_length = l8;
    bus.parity_type = par;
    bus.baud_rate   = br;
    bus.data_tx     = 1'b0;
    repeat (4 * tk) @(negedge clock);
    if (scramble) begin
      bus.stop_bits   = ~s2;
      bus.data_length = ~l8;
      bus.parity_type = 2'($urandom_range(0, 3));
      bus.baud_rate   = ~br;
    end
    repeat (12 * tk) @(negedge clock);
    for (int i = 0; i < nb; i++) begin
      bus.data_tx = dm[i];
      repeat (16 * tk) @(negedge clock);
    end
    if (pon) begin
      bus.data_tx = pbit;
      repeat (16 * tk) @(negedge clock);
    end
    for (int s = 0; s < ns; s++) begin
      bus.data_tx = ~stop_low[s];
      repeat ((s == ns - 1) ? last_ticks * tk : 16 * tk) @(negedge clock);
    end
    exp_data = dm;
    exp_pe   = pon & flip;
    exp_se   = stop_low[0] | (s2 & stop_low[1]);
  endtask

  task automatic test_reset();
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset data_out got %02h exp 00", bus.data_out); end
    checks++; if (bus.parity_error !== 1'b0) begin errors++; $display("FAIL reset parity_error got %b exp 0", bus.parity_error); end
    checks++; if (bus.stop_error !== 1'b0) begin errors++; $display("FAIL reset stop_error got %b exp 0", bus.stop_error); end
    checks++; if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL reset rx_active got %b exp 0", bus.rx_active); end
    checks++; if (bus.rx_done !== 1'b0) begin errors++; $display("FAIL reset rx_done got %b exp 0", bus.rx_done); end
  endtask

  task automatic test_even_8bit();
    int base;
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 2'b00, 16, 1'b0);
    idle(32 * tick_clks(2'b10));
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL even8 rx_done count got %0d exp 1", done_cnt - base); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL even8 data_out got %02h exp a5", bus.data_out); end
    checks++; if (bus.parity_error !== 1'b0) begin errors++; $display("FAIL even8 parity_error got %b exp 0", bus.parity_error); end
    checks++; if (bus.stop_error !== 1'b0) begin errors++; $display("FAIL even8 stop_error got %b exp 0", bus.stop_error); end
    checks++; if (cap_act !== 1'b0) begin errors++; $display("FAIL even8 rx_active at done got %b exp 0", cap_act); end
  endtask

  task automatic test_odd_7bit();
    int base;
    base = done_cnt;
    send_frame(8'h35, 1'b1, 1'b0, 2'b01, 2'b11, 1'b0, 2'b00, 16, 1'b0);
    idle(32 * tick_clks(2'b11));
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL odd7 rx_done count got %0d exp 1", done_cnt - base); end
    checks++; if (bus.data_out !== 8'h35) begin errors++; $display("FAIL odd7 data_out got %02h exp 35", bus.data_out); end
    checks++; if (bus.parity_error !== 1'b0) begin errors++; $display("FAIL odd7 parity_error got %b exp 0", bus.parity_error); end
    checks++; if (bus.stop_error !== 1'b0) begin errors++; $display("FAIL odd7 stop_error got %b exp 0", bus.stop_error); end
  endtask

  task automatic test_parity_error();
    int base;
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 2'b00, 16, 1'b0);
    idle(32 * tick_clks(2'b10));
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL parerr rx_done count got %0d exp 1", done_cnt - base); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL parerr data_out got %02h exp a5", bus.data_out); end
    checks++; if (bus.parity_error !== 1'b1) begin errors++; $display("FAIL parerr parity_error got %b exp 1", bus.parity_error); end
    checks++; if (bus.stop_error !== 1'b0) begin errors++; $display("FAIL parerr stop_error got %b exp 0", bus.stop_error); end
  endtask

  task automatic test_stop_error();
    int base;
    base = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 2'b01, 16, 1'b0);
    idle(32 * tick_clks(2'b10));
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL stoperr rx_done count got %0d exp 1", done_cnt - base); end
    checks++; if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL stoperr data_out got %02h exp 3c", bus.data_out); end
    checks++; if (bus.parity_error !== 1'b0) begin errors++; $display("FAIL stoperr parity_error got %b exp 0", bus.parity_error); end
    checks++; if (bus.stop_error !== 1'b1) begin errors++; $display("FAIL stoperr stop_error got %b exp 1", bus.stop_error); end
  endtask

  task automatic test_glitch();
    int base;
    int tk;
    tk = tick_clks(2'b10);
    bus.baud_rate = 2'b10;
    base = done_cnt;
    bus.data_tx = 1'b0;
    repeat (4 * tk) @(negedge clock);
    checks++; if (bus.rx_active !== 1'b1) begin errors++; $display("FAIL glitch rx_active during low got %b exp 1", bus.rx_active); end
    idle(32 * tk);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL glitch rx_done count got %0d exp 0", done_cnt - base); end
    checks++; if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL glitch rx_active after got %b exp 0", bus.rx_active); end
    checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL glitch data_out got %02h exp %02h", bus.data_out, exp_data); end
    checks++; if (bus.parity_error !== exp_pe) begin errors++; $display("FAIL glitch parity_error got %b exp %b", bus.parity_error, exp_pe); end
    checks++; if (bus.stop_error !== exp_se) begin errors++; $display("FAIL glitch stop_error got %b exp %b", bus.stop_error, exp_se); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int lens [3];
    int base;
    bytes[0] = 8'h01; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    lens[0]  = 16;    lens[1]  = 12;    lens[2]  = 16;
    for (int f = 0; f < 3; f++) begin
      base = done_cnt;
      send_frame(bytes[f], 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, lens[f], 1'b0);
      checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL b2b frame %0d rx_done count got %0d exp 1", f, done_cnt - base); end
      checks++; if (bus.data_out !== bytes[f]) begin errors++; $display("FAIL b2b frame %0d data_out got %02h exp %02h", f, bus.data_out, bytes[f]); end
    end
    idle(32 * tick_clks(2'b10));
  endtask

  task automatic test_reset_mid_frame();
    int tk;
    int base;
    logic [7:0] d;
    tk = tick_clks(2'b10);
    d  = 8'h55;
    bus.stop_bits = 1'b0; bus.data_length = 1'b1; bus.parity_type = 2'b00; bus.baud_rate = 2'b10;
    bus.data_tx = 1'b0;
    repeat (16 * tk) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus.data_tx = d[i];
      repeat (16 * tk) @(negedge clock);
    end
    base = done_cnt;
    rst = 1'b0;
    #1;
    exp_data = 8'h00; exp_pe = 1'b0; exp_se = 1'b0;
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rstmid data_out got %02h exp 00", bus.data_out); end
    checks++; if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL rstmid rx_active got %b exp 0", bus.rx_active); end
    checks++; if (bus.stop_error !== 1'b0) begin errors++; $display("FAIL rstmid stop_error got %b exp 0", bus.stop_error); end
    @(negedge clock);
    idle(4);
    rst = 1'b1;
    idle(32 * tk);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL rstmid spurious rx_done count got %0d exp 0", done_cnt - base); end
    base = done_cnt;
    send_frame(8'h0F, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 16, 1'b0);
    idle(32 * tk);
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL rstmid next rx_done count got %0d exp 1", done_cnt - base); end
    checks++; if (bus.data_out !== 8'h0F) begin errors++; $display("FAIL rstmid next data_out got %02h exp 0f", bus.data_out); end
  endtask

  task automatic test_random();
    int base;
    logic [7:0] d;
    logic s2, l8, flip;
    logic [1:0] par, br, sl;
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      s2   = 1'($urandom_range(0, 1));
      l8   = 1'($urandom_range(0, 1));
      par  = 2'($urandom_range(0, 3));
      br   = 2'($urandom_range(1, 3));
      flip = ($urandom_range(0, 2) == 0);
      sl   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      base = done_cnt;
      send_frame(d, s2, l8, par, br, flip, sl, 16, 1'b1);
      idle(32 * tick_clks(br));
      checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL rand %0d rx_done count got %0d exp 1", n, done_cnt - base); end
      checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL rand %0d data_out got %02h exp %02h", n, bus.data_out, exp_data); end
      checks++; if (bus.parity_error !== exp_pe) begin errors++; $display("FAIL rand %0d parity_error got %b exp %b", n, bus.parity_error, exp_pe); end
      checks++; if (bus.stop_error !== exp_se) begin errors++; $display("FAIL rand %0d stop_error got %b exp %b", n, bus.stop_error, exp_se); end
    end
  endtask

  initial begin
    rst             = 1'b0;
    bus.data_tx     = 1'b1;
    bus.stop_bits   = 1'b0;
    bus.data_length = 1'b1;
    bus.parity_type = 2'b00;
    bus.baud_rate   = 2'b10;
    repeat (3) @(negedge clock);
    test_reset();
    rst = 1'b1;
    idle(20);
    test_even_8bit();
    test_odd_7bit();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
